sram_puf_ctrl: RTL
==================

SRAM_PUF_CTRL -- requirements
Module: sram_puf_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 16: number of PUF bytes read per response; legal range 1..64.
REQ-002 SHALL have parameter CMP_OFFSET, default 32: address distance from the primary block to the comparison block.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to read one response.
REQ-006 SHALL have port base_addr, input, 32 bits: first PUF byte address, sampled when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking response (and hd) valid.
REQ-009 SHALL have port response, output, NBYTES*8 bits: packed PUF bytes, byte i at bits [8i+7:8i].
REQ-010 SHALL have port hd, output, $clog2(NBYTES*8+1) bits: Hamming distance between the primary and comparison blocks.
REQ-011 SHALL have port mem_addr, output, 32 bits: address driven to the PUF SRAM.
REQ-012 SHALL have port mem_re, output, 1 bit: read enable driven to the PUF SRAM.
REQ-013 SHALL have port mem_q, input, 8 bits: SRAM data, valid on the cycle after mem_re=1 (registered read, latency 1).

Function
REQ-014 SHALL implement the FSM states IDLE, RD_PRI, RD_CMP and DONE.
REQ-015 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-016 SHALL do the following on acceptance (edge 0): latch base_addr, clear response and hd to 0, enter RD_PRI.
REQ-017 SHALL in RD_PRI assert mem_re for NBYTES consecutive cycles (cycles 1..NBYTES) with mem_addr = base_addr+k, k=0..NBYTES-1; addresses wrap modulo 2^32.
REQ-018 SHALL capture mem_q one cycle after each read into response byte k.
REQ-019 SHALL (HD enabled) enter RD_CMP without a bubble and issue NBYTES reads at base_addr+CMP_OFFSET+k.
REQ-020 SHALL (HD enabled) add popcount(response byte k XOR mem_q) to hd one cycle after each RD_CMP read.
REQ-021 SHALL hold mem_re=0 and mem_addr at its last value outside read cycles.
REQ-022 SHALL pulse done for exactly one cycle in DONE: at cycle NBYTES+2 (HD disabled) or 2*NBYTES+2 (HD enabled) after acceptance; then return to IDLE.
REQ-023 SHALL hold response and hd stable from done until the next accepted start.
REQ-024 SHALL ignore start asserted in the same cycle as done; it is accepted only on a later cycle while in IDLE.
REQ-025 SHALL keep hd width sufficient for all-bits-differ (NBYTES*8) with no overflow.

Reset
REQ-026 SHALL make rst override start in the same cycle.
REQ-027 SHALL on rst, at any state including mid-read: state=IDLE, busy=0, done=0, mem_re=0, mem_addr=0, response=0, hd=0.
REQ-028 SHALL discard any in-flight mem_q return after reset.

Configuration
REQ-029 SHALL use the macro SRAM_PUF_HD_EN: when defined, RD_CMP and the Hamming-distance accumulator are compiled in.
REQ-030 SHALL, when SRAM_PUF_HD_EN is undefined, omit RD_CMP (RD_PRI goes to DONE), tie hd to 0, and keep the port list unchanged.

Structure
REQ-031 SHALL place the state enum and the NBYTES/CMP_OFFSET default constants in the shared package sram_puf_pkg.
REQ-032 SHALL use one sub-module, popcount8: combinational 8-bit popcount returning 4 bits.

Verification (SRAM loaded with the hardcoded PUF image; NBYTES=16, CMP_OFFSET=32)
REQ-033 SHALL cover: start, base_addr=0 -> response=128'h99d3dd8adcd8dfb1d1b128f73b220aa3; done at cycle 18 (HD off) or 34 (HD on).
REQ-034 SHALL cover: HD on, base_addr=0 -> hd=1 (byte 3: 3b vs 3a).
REQ-035 SHALL cover: HD on, base_addr=16 -> comparison block reads default 00 -> hd=61.
REQ-036 SHALL cover: start pulsed while busy and in the done cycle -> ignored; exactly one done per accepted start.
REQ-037 SHALL cover: rst at cycle 5 of RD_PRI -> next cycle busy=0, mem_re=0, response=0; a fresh start then yields a correct result.
REQ-038 SHALL cover: base_addr=32'hFFFFFFF8 -> mem_addr wraps to 0..7 after FFFFFFFF; default bytes 00 in the response.

Source files
------------

// File: rtl/sram_puf_pkg.sv
// ---------------------------------------------------------------------------
// sram_puf_pkg
// Shared definitions for the SRAM PUF read controller.
//   - state_e        : controller FSM states
//   - NBYTES_DEF     : default number of PUF bytes per response
//   - CMP_OFFSET_DEF : default address distance to the comparison block
// ---------------------------------------------------------------------------
package sram_puf_pkg;

    localparam int unsigned NBYTES_DEF     = 16;
    localparam int unsigned CMP_OFFSET_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_PRI = 2'd1,
        RD_CMP = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/popcount8.sv
// ---------------------------------------------------------------------------
// popcount8
// Combinational population count of one byte.
//   data_i  [7:0] : byte to count
//   count_o [3:0] : number of set bits (0..8)
// ---------------------------------------------------------------------------
module popcount8 (
    input  logic [7:0] data_i,
    output logic [3:0] count_o
);

    always_comb begin
        count_o = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count_o = count_o + {3'd0, data_i[i]};
        end
    end

endmodule

// File: rtl/sram_puf_ctrl.sv
// ---------------------------------------------------------------------------
// sram_puf_ctrl
// Reads an NBYTES-byte PUF response from an SRAM with a registered read port
// (data returns one cycle after mem_re). With SRAM_PUF_HD_EN defined, a second
// block at base_addr+CMP_OFFSET is read straight after the first and the
// Hamming distance between the two blocks is accumulated into hd. Without the
// macro the comparison pass is absent and hd is tied to 0.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : request one response (accepted only in IDLE)
//   base_addr : first PUF byte address, latched on acceptance
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse, response/hd valid
//   response  : packed PUF bytes, byte i at [8i+7:8i]
//   hd        : Hamming distance primary vs comparison block
//   mem_addr  : SRAM address
//   mem_re    : SRAM read enable
//   mem_q     : SRAM read data, latency 1
// ---------------------------------------------------------------------------
module sram_puf_ctrl
    import sram_puf_pkg::*;
#(
    parameter int unsigned NBYTES     = NBYTES_DEF,
    parameter int unsigned CMP_OFFSET = CMP_OFFSET_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [31:0]                     base_addr,
    output logic                            busy,
    output logic                            done,
    output logic [NBYTES*8-1:0]             response,
    output logic [$clog2(NBYTES*8+1)-1:0]   hd,
    output logic [31:0]                     mem_addr,
    output logic                            mem_re,
    input  logic [7:0]                      mem_q
);

    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned HD_W  = $clog2(NBYTES*8+1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES-1);

    state_e                 state_q,  state_d;
    logic [31:0]            addr_q,   addr_d;
    logic                   re_q,     re_d;
    logic [IDX_W-1:0]       idx_q,    idx_d;     // byte index of the read issued this cycle
    logic                   rd_vld_q, rd_vld_d;  // mem_q carries a requested byte this cycle
    logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;  // which byte mem_q belongs to
    logic [NBYTES*8-1:0]    resp_q,   resp_d;

`ifdef SRAM_PUF_HD_EN
    logic [31:0]            base_q,   base_d;
    logic                   rd_cmp_q, rd_cmp_d;  // mem_q belongs to the comparison block
    logic [HD_W-1:0]        hd_q,     hd_d;
    logic [7:0]             diff;
    logic [3:0]             diff_cnt;

    assign diff = resp_q[{rd_idx_q, 3'b000} +: 8] ^ mem_q;

    popcount8 u_popcount8 (
        .data_i  (diff),
        .count_o (diff_cnt)
    );
`endif

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        re_d     = 1'b0;
        idx_d    = idx_q;
        rd_vld_d = 1'b0;
        rd_idx_d = rd_idx_q;
        resp_d   = resp_q;
`ifdef SRAM_PUF_HD_EN
        base_d   = base_q;
        rd_cmp_d = rd_cmp_q;
        hd_d     = hd_q;
`endif

        // Return path: the byte requested last cycle is on mem_q now.
        if (rd_vld_q) begin
`ifdef SRAM_PUF_HD_EN
            if (rd_cmp_q) begin
                hd_d = hd_q + HD_W'(diff_cnt);
            end else begin
                resp_d[{rd_idx_q, 3'b000} +: 8] = mem_q;
            end
`else
            resp_d[{rd_idx_q, 3'b000} +: 8] = mem_q;
`endif
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_PRI;
                    addr_d  = base_addr;
                    re_d    = 1'b1;
                    idx_d   = '0;
                    resp_d  = '0;
`ifdef SRAM_PUF_HD_EN
                    base_d  = base_addr;
                    hd_d    = '0;
`endif
                end
            end

            // Issue phase while re_q is high; one extra cycle with re_q low
            // drains the last return before DONE (unless RD_CMP takes over).
            RD_PRI: begin
                if (re_q) begin
                    rd_vld_d = 1'b1;
                    rd_idx_d = idx_q;
`ifdef SRAM_PUF_HD_EN
                    rd_cmp_d = 1'b0;
`endif
                    if (idx_q != LAST_IDX) begin
                        re_d   = 1'b1;
                        addr_d = addr_q + 32'd1;
                        idx_d  = idx_q + IDX_W'(1);
                    end
`ifdef SRAM_PUF_HD_EN
                    else begin
                        state_d = RD_CMP;
                        re_d    = 1'b1;
                        addr_d  = base_q + 32'(CMP_OFFSET);
                        idx_d   = '0;
                    end
`endif
                end else begin
                    state_d = DONE;
                end
            end

`ifdef SRAM_PUF_HD_EN
            RD_CMP: begin
                if (re_q) begin
                    rd_vld_d = 1'b1;
                    rd_idx_d = idx_q;
                    rd_cmp_d = 1'b1;
                    if (idx_q != LAST_IDX) begin
                        re_d   = 1'b1;
                        addr_d = addr_q + 32'd1;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = DONE;
                end
            end
`endif

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            re_q     <= 1'b0;
            idx_q    <= '0;
            rd_vld_q <= 1'b0;   // drops any read still in flight
            rd_idx_q <= '0;
            resp_q   <= '0;
`ifdef SRAM_PUF_HD_EN
            base_q   <= '0;
            rd_cmp_q <= 1'b0;
            hd_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            re_q     <= re_d;
            idx_q    <= idx_d;
            rd_vld_q <= rd_vld_d;
            rd_idx_q <= rd_idx_d;
            resp_q   <= resp_d;
`ifdef SRAM_PUF_HD_EN
            base_q   <= base_d;
            rd_cmp_q <= rd_cmp_d;
            hd_q     <= hd_d;
`endif
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign response = resp_q;
    assign mem_addr = addr_q;
    assign mem_re   = re_q;
`ifdef SRAM_PUF_HD_EN
    assign hd       = hd_q;
`else
    assign hd       = '0;
`endif

endmodule
